cra_seq: RTL and testbench
==========================

Name: cra_seq

Overview:
- Parametrised microcode address sequencer; the next generation of the CRAM address/call-return logic in the EBOX.
- Forms the next CRAM address each cycle by ORing:
  - the J field,
  - an optional page-fail force mask,
  - one of N dispatch sources,
  - the COND_ADR_10 bit.
- Owns a configurable-depth CALL/RETURN stack with full/empty status, sticky overflow/underflow error flags, a clock enable, and diagnostic load and stack-readback paths.

Parameters:
- ADR_W, 11: CRAM address width.
- DEPTH, 16: stack entries. Must be a power of two, at least 2. SP_W = $clog2(DEPTH).
- N_DISP, 8: number of dispatch sources. DSEL_W = $clog2(N_DISP).
- FORCE_MASK, 11'b01111111110: OR mask applied on force (the 1777 trap).

Ports:
- clk  in  1  system clock.
- RESET  in  1  synchronous, active-high.
- en  in  1  cycle advance; when low, all state holds.
- j  in  ADR_W  CRAM J field.
- condAdr  in  1  ORed into bit ADR_W-1 (LSB).
- dispEn  in  1  enables the dispatch OR term.
- dispSel  in  DSEL_W  dispatch source select.
- dispSrc  in  N_DISP*ADR_W  flattened dispatch sources; source k is at [k*ADR_W +: ADR_W].
- call  in  1  microcode CALL.
- ret  in  1  microcode RETURN.
- force  in  1  page-fail synthetic call.
- diagLoad  in  1  load CRADR from diagAdr.
- diagAdr  in  ADR_W  diagnostic address.
- diagIdx  in  SP_W  stack entry index for readback.
- errClr  in  1  clears the sticky error flags.
- cradr  out  ADR_W  current CRAM address (registered).
- sbrRet  out  ADR_W  top-of-stack value, stack[sp-1]; 0 when empty.
- sp  out  SP_W+1  stack occupancy, 0..DEPTH.
- full  out  1  sp == DEPTH.
- empty  out  1  sp == 0.
- overflow  out  1  sticky error flag.
- underflow  out  1  sticky error flag.
- diagData  out  ADR_W  stack[diagIdx], combinational.

Behaviour:
- All state changes on posedge clk.
- RESET has priority over everything, including en:
  - cradr=0, sp=0, overflow=0, underflow=0.
  - Stack contents are not cleared; reads of empty slots are don't-care except sbrRet, which is 0 when empty.
- If en=0 and RESET=0, everything holds, errClr included.
- With en=1, priority is diagLoad > force > call > ret > plain:
  - diagLoad: cradr<=diagAdr. Stack and sp unchanged.
  - force: push cradr (the old value) at stack[sp]; sp<=sp+1; next = j | FORCE_MASK | disp | condAdr. ret is ignored this cycle.
  - call (no force): push cradr as above; next = j | disp | condAdr.
  - ret (no force, no call): next = j | sbrRet | disp | condAdr; sp<=sp-1.
  - plain: next = j | disp | condAdr.
- disp term = dispEn ? dispSrc[dispSel] : 0. A dispSel of N_DISP or more gives 0.
- Push when full (sp==DEPTH):
  - no write, sp stays DEPTH, overflow<=1;
  - the address is still formed normally.
- Pop when empty:
  - sp stays 0, sbrRet contributes 0, underflow<=1.
- errClr (en=1) clears both flags. If a new error occurs in the same cycle, the set wins.
- Latency: one cycle from inputs to cradr. sbrRet, full, empty and diagData are combinational from registered state.
- Push and pop never occur in the same cycle, so sp changes by at most ±1.

Decomposition:
- Package cra_seq_pkg holds:
  - parametrised typedefs tCradr (logic [0:ADR_W-1]) and tSp;
  - localparam FORCE_1777;
  - enum tSeqOp {OP_PLAIN, OP_DIAG, OP_FORCE, OP_CALL, OP_RET}, a decoded priority result usable by both RTL and bench.
- One sub-module, cra_lifo:
  - the stack array, sp, full, empty and error flags;
  - push/pop/clr inputs, top and diag read outputs.
- cra_seq keeps the op decode, dispatch mux and CRADR register.

Test Plan:
1. Reset/hold: RESET=1 for 1 cycle with j=0x155 -> cradr=0, sp=0, empty=1. Then en=0, j=0x155 -> cradr stays 0.
2. Nested call/return: cradr=0x010, call, j=0x200 -> cradr=0x200, sp=1. Call, j=0x300 -> sp=2, sbrRet=0x200. ret, j=0 -> cradr=0x200, sp=1. ret -> cradr=0x010, sp=0.
3. Force beats ret: cradr=0x123, sp=1, force=1, ret=1, j=0 -> cradr=0x3FE, sp=2, stack[1]=0x123 via diagIdx=1.
4. Overflow: DEPTH+1 consecutive calls -> sp=DEPTH, full=1, overflow=1, stack[DEPTH-1] holds the DEPTH-th address. errClr -> overflow=0.
5. Underflow: ret with sp=0, j=0x040 -> cradr=0x040, sp=0, underflow=1.
6. Dispatch OR: dispEn=1, dispSel=3, src3=0x00E, j=0x400, condAdr=1 -> cradr=0x40F. dispSel=N_DISP (if encodable) -> cradr=0x401.

Source files
------------

// File: rtl/cra_seq_pkg.sv
// Shared types for the CRAM address sequencer: address/occupancy typedefs,
// the page-fail trap mask and the decoded per-cycle operation.
package cra_seq_pkg;

    localparam int CRA_ADR_W = 11;
    localparam int CRA_DEPTH = 16;
    localparam int CRA_SP_W  = $clog2(CRA_DEPTH);

    // Bit 0 is the MSB, bit ADR_W-1 the LSB, matching the EBOX drawings.
    typedef logic [0:CRA_ADR_W-1] tCradr;
    typedef logic [CRA_SP_W:0]    tSp;

    // The 1777 trap: every bit but the MSB and the COND_ADR_10 position.
    localparam tCradr FORCE_1777 = 11'b01111111110;

    typedef enum logic [2:0] {
        OP_PLAIN,
        OP_DIAG,
        OP_FORCE,
        OP_CALL,
        OP_RET
    } tSeqOp;

    // Priority: diagnostic load > page-fail force > call > return > plain.
    function automatic tSeqOp seq_decode(input logic diagLoad,
                                         input logic forceTrap,
                                         input logic call,
                                         input logic ret);
        tSeqOp op;
        op = OP_PLAIN;
        if (diagLoad)       op = OP_DIAG;
        else if (forceTrap) op = OP_FORCE;
        else if (call)      op = OP_CALL;
        else if (ret)       op = OP_RET;
        return op;
    endfunction

endpackage

// File: rtl/cra_lifo.sv
// CALL/RETURN stack: occupancy pointer, full/empty status, sticky
// overflow/underflow flags, top-of-stack and indexed diagnostic reads.
module cra_lifo
    import cra_seq_pkg::*;
#(
    parameter int ADR_W = CRA_ADR_W,
    parameter int DEPTH = CRA_DEPTH,
    localparam int SP_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               RESET,
    input  logic               en,
    input  logic               push,
    input  logic               pop,
    input  logic               clr,
    input  logic [0:ADR_W-1]   din,
    input  logic [SP_W-1:0]    diagIdx,
    output logic [0:ADR_W-1]   top,
    output logic [0:ADR_W-1]   diagData,
    output logic [SP_W:0]      sp,
    output logic               full,
    output logic               empty,
    output logic               overflow,
    output logic               underflow
);

    logic [0:ADR_W-1] mem [DEPTH];
    logic [SP_W-1:0]  topIdx;
    logic             ovfSet;
    logic             unfSet;

    assign full   = (sp == (SP_W+1)'(DEPTH));
    assign empty  = (sp == '0);
    // At sp == DEPTH the low bits wrap to 0, so subtracting 1 lands on DEPTH-1.
    assign topIdx = sp[SP_W-1:0] - SP_W'(1);
    assign top      = empty ? '0 : mem[topIdx];
    assign diagData = mem[diagIdx];

    assign ovfSet = push && full;
    assign unfSet = pop && empty;

    // Stack storage: written on a non-overflowing push; never reset.
    always_ff @(posedge clk) begin
        if (en && push && !full)
            mem[sp[SP_W-1:0]] <= din;
    end

    // Occupancy and sticky error flags; a new error beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (RESET) begin
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (en) begin
            if (push && !full)
                sp <= sp + (SP_W+1)'(1);
            else if (pop && !empty)
                sp <= sp - (SP_W+1)'(1);
            overflow  <= ovfSet | (overflow  & ~clr);
            underflow <= unfSet | (underflow & ~clr);
        end
    end

endmodule

// File: rtl/cra_seq.sv
// CRAM address sequencer: decodes the cycle operation, ORs J, trap mask,
// dispatch and COND_ADR_10 into the next address, and drives the return
// stack. The page-fail input is named forceTrap because force is reserved.
module cra_seq
    import cra_seq_pkg::*;
#(
    parameter int ADR_W = CRA_ADR_W,
    parameter int DEPTH = CRA_DEPTH,
    parameter int N_DISP = 8,
    parameter logic [0:ADR_W-1] FORCE_MASK = FORCE_1777,
    localparam int SP_W = $clog2(DEPTH),
    localparam int DSEL_W = $clog2(N_DISP)
) (
    input  logic                      clk,
    input  logic                      RESET,
    input  logic                      en,
    input  logic [0:ADR_W-1]          j,
    input  logic                      condAdr,
    input  logic                      dispEn,
    input  logic [DSEL_W-1:0]         dispSel,
    input  logic [N_DISP*ADR_W-1:0]   dispSrc,
    input  logic                      call,
    input  logic                      ret,
    input  logic                      forceTrap,
    input  logic                      diagLoad,
    input  logic [0:ADR_W-1]          diagAdr,
    input  logic [SP_W-1:0]           diagIdx,
    input  logic                      errClr,
    output logic [0:ADR_W-1]          cradr,
    output logic [0:ADR_W-1]          sbrRet,
    output logic [SP_W:0]             sp,
    output logic                      full,
    output logic                      empty,
    output logic                      overflow,
    output logic                      underflow,
    output logic [0:ADR_W-1]          diagData
);

    tSeqOp            op;
    logic [0:ADR_W-1] disp;
    logic [0:ADR_W-1] base;
    logic [0:ADR_W-1] nextAdr;
    logic [0:ADR_W-1] cradr_p1;
    logic             push;
    logic             pop;

    assign op   = seq_decode(diagLoad, forceTrap, call, ret);
    assign push = (op == OP_FORCE) || (op == OP_CALL);
    assign pop  = (op == OP_RET);

    // Dispatch mux; selects at or beyond N_DISP contribute nothing.
    always_comb begin
        disp = '0;
        if (dispEn) begin
            for (int k = 0; k < N_DISP; k++) begin
                if (dispSel == DSEL_W'(k))
                    disp = dispSrc[k*ADR_W +: ADR_W];
            end
        end
    end

    assign base = j | disp | {{(ADR_W-1){1'b0}}, condAdr};

    // Next-address formation; sbrRet is already 0 when the stack is empty.
    always_comb begin
        nextAdr = base;
        case (op)
            OP_DIAG:  nextAdr = diagAdr;
            OP_FORCE: nextAdr = base | FORCE_MASK;
            OP_RET:   nextAdr = base | sbrRet;
            default:  nextAdr = base;
        endcase
    end

    // ---- stage boundary: CRADR register ----
    always_ff @(posedge clk) begin
        if (RESET)
            cradr_p1 <= '0;
        else if (en)
            cradr_p1 <= nextAdr;
    end

    assign cradr = cradr_p1;

    cra_lifo #(
        .ADR_W (ADR_W),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk       (clk),
        .RESET     (RESET),
        .en        (en),
        .push      (push),
        .pop       (pop),
        .clr       (errClr),
        .din       (cradr_p1),
        .diagIdx   (diagIdx),
        .top       (sbrRet),
        .diagData  (diagData),
        .sp        (sp),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

endmodule

// File: tb/tb_cra_seq.sv
// Directed bench for cra_seq with hand-computed expected addresses.
// N_DISP is 6 so that an out-of-range dispatch select is encodable.
module tb_cra_seq;
    import cra_seq_pkg::*;

    localparam int ADR_W  = 11;
    localparam int DEPTH  = 16;
    localparam int N_DISP = 6;
    localparam int SP_W   = $clog2(DEPTH);
    localparam int DSEL_W = $clog2(N_DISP);

    logic                    clk = 1'b0;
    logic                    RESET;
    logic                    en;
    logic [0:ADR_W-1]        j;
    logic                    condAdr;
    logic                    dispEn;
    logic [DSEL_W-1:0]       dispSel;
    logic [N_DISP*ADR_W-1:0] dispSrc;
    logic                    call;
    logic                    ret;
    logic                    forceTrap;
    logic                    diagLoad;
    logic [0:ADR_W-1]        diagAdr;
    logic [SP_W-1:0]         diagIdx;
    logic                    errClr;
    logic [0:ADR_W-1]        cradr;
    logic [0:ADR_W-1]        sbrRet;
    logic [SP_W:0]           sp;
    logic                    full;
    logic                    empty;
    logic                    overflow;
    logic                    underflow;
    logic [0:ADR_W-1]        diagData;

    int nChk  = 0;
    int nPass = 0;

    cra_seq #(
        .ADR_W  (ADR_W),
        .DEPTH  (DEPTH),
        .N_DISP (N_DISP)
    ) dut (
        .clk       (clk),
        .RESET     (RESET),
        .en        (en),
        .j         (j),
        .condAdr   (condAdr),
        .dispEn    (dispEn),
        .dispSel   (dispSel),
        .dispSrc   (dispSrc),
        .call      (call),
        .ret       (ret),
        .forceTrap (forceTrap),
        .diagLoad  (diagLoad),
        .diagAdr   (diagAdr),
        .diagIdx   (diagIdx),
        .errClr    (errClr),
        .cradr     (cradr),
        .sbrRet    (sbrRet),
        .sp        (sp),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow),
        .diagData  (diagData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChk++;
        if (obs === exp)
            nPass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Return controls to an idle, enabled, plain cycle.
    task automatic idle();
        RESET = 1'b0; en = 1'b1; j = '0; condAdr = 1'b0; dispEn = 1'b0;
        dispSel = '0; call = 1'b0; ret = 1'b0; forceTrap = 1'b0;
        diagLoad = 1'b0; diagAdr = '0; diagIdx = '0; errClr = 1'b0;
    endtask

    // Advance one clock and settle past the edge before sampling.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [0:ADR_W-1] src [N_DISP];
        src[0] = 11'h011; src[1] = 11'h022; src[2] = 11'h044;
        src[3] = 11'h00E; src[4] = 11'h088; src[5] = 11'h100;
        for (int k = 0; k < N_DISP; k++)
            dispSrc[k*ADR_W +: ADR_W] = src[k];

        // Reset and hold
        idle(); RESET = 1'b1; j = 11'h155;
        cyc();
        chk("rst_cradr", 32'(cradr), 32'h000);
        chk("rst_sp", 32'(sp), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ovf", 32'(overflow), 32'd0);
        RESET = 1'b0; en = 1'b0;
        cyc();
        chk("hold_cradr", 32'(cradr), 32'h000);

        // Nested call/return
        idle(); j = 11'h010;
        cyc();
        chk("plain_cradr", 32'(cradr), 32'h010);
        call = 1'b1; j = 11'h200;
        cyc();
        chk("call1_cradr", 32'(cradr), 32'h200);
        chk("call1_sp", 32'(sp), 32'd1);
        chk("call1_top", 32'(sbrRet), 32'h010);
        j = 11'h300;
        cyc();
        chk("call2_sp", 32'(sp), 32'd2);
        chk("call2_top", 32'(sbrRet), 32'h200);
        call = 1'b0; ret = 1'b1; j = '0;
        cyc();
        chk("ret1_cradr", 32'(cradr), 32'h200);
        chk("ret1_sp", 32'(sp), 32'd1);
        cyc();
        chk("ret2_cradr", 32'(cradr), 32'h010);
        chk("ret2_sp", 32'(sp), 32'd0);
        chk("ret2_empty", 32'(empty), 32'd1);
        chk("ret2_top", 32'(sbrRet), 32'h000);

        // Force beats ret
        idle(); call = 1'b1; j = 11'h123;
        cyc();
        chk("pre_force_sp", 32'(sp), 32'd1);
        idle(); forceTrap = 1'b1; ret = 1'b1; diagIdx = 4'd1;
        cyc();
        chk("force_cradr", 32'(cradr), 32'h3FE);
        chk("force_sp", 32'(sp), 32'd2);
        chk("force_stk1", 32'(diagData), 32'h123);
        chk("force_unf", 32'(underflow), 32'd0);

        // Overflow: DEPTH+1 calls with j = 1..DEPTH+1
        idle(); RESET = 1'b1;
        cyc();
        idle(); call = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            j = 11'(i);
            cyc();
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ovf", 32'(overflow), 32'd0);
        chk("fill_top", 32'(sbrRet), 32'(DEPTH-1));
        j = 11'(DEPTH+1);
        cyc();
        chk("ovf_cradr", 32'(cradr), 32'(DEPTH+1));
        chk("ovf_sp", 32'(sp), 32'(DEPTH));
        chk("ovf_flag", 32'(overflow), 32'd1);
        diagIdx = 4'(DEPTH-1);
        #1;
        chk("ovf_stk_last", 32'(diagData), 32'(DEPTH-1));
        errClr = 1'b1;
        cyc();
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        idle(); en = 1'b0; errClr = 1'b1;
        cyc();
        chk("ovf_hold_en0", 32'(overflow), 32'd1);
        en = 1'b1;
        cyc();
        chk("ovf_clr", 32'(overflow), 32'd0);
        chk("ovf_clr_sp", 32'(sp), 32'(DEPTH));

        // Underflow
        idle(); RESET = 1'b1;
        cyc();
        idle(); ret = 1'b1; j = 11'h040;
        cyc();
        chk("unf_cradr", 32'(cradr), 32'h040);
        chk("unf_sp", 32'(sp), 32'd0);
        chk("unf_flag", 32'(underflow), 32'd1);
        idle(); errClr = 1'b1;
        cyc();
        chk("unf_clr", 32'(underflow), 32'd0);

        // Dispatch OR and out-of-range select
        idle(); dispEn = 1'b1; dispSel = 3'd3; j = 11'h400; condAdr = 1'b1;
        cyc();
        chk("disp3", 32'(cradr), 32'h40F);
        dispSel = 3'd5;
        cyc();
        chk("disp5", 32'(cradr), 32'h501);
        dispSel = 3'(N_DISP);
        cyc();
        chk("disp_oor", 32'(cradr), 32'h401);
        dispSel = 3'd3; dispEn = 1'b0;
        cyc();
        chk("disp_off", 32'(cradr), 32'h401);

        // Diagnostic load outranks call and leaves the stack alone
        idle(); diagLoad = 1'b1; diagAdr = 11'h7A5; call = 1'b1;
        cyc();
        chk("diag_cradr", 32'(cradr), 32'h7A5);
        chk("diag_sp", 32'(sp), 32'd0);

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule
